mult_div_unit: RTL and testbench

- Parametrised iterative multiply/divide unit with dedicated HI/LO result registers.
- Serves MULT, MULTU, DIV, DIVU, MFHI/MFLO, MTHI and MTLO for the multicycle MIPS datapath.
- Sits beside the ALU. The control FSM starts an operation, waits on `busy`/`done`, then reads `hi`/`lo` into the register write-data path.
- Generalises the former single-cycle `mul` path to any operand width. Adds signed/unsigned modes, division, and a start/done handshake.

---
 rtl/mdu_pkg.sv | 26 ++
 rtl/mult_div_unit.sv | 145 ++++++++++++++
 tb/tb_mult_div_unit.sv | 199 +++++++++++++++++++
 3 files changed

// File: rtl/mdu_pkg.sv
// Shared types for the iterative multiply/divide unit and the control FSM that drives it.
package mdu_pkg;

  typedef enum logic [1:0] {
    OP_MULT  = 2'b00,
    OP_MULTU = 2'b01,
    OP_DIV   = 2'b10,
    OP_DIVU  = 2'b11
  } mdu_op_t;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_PREP = 2'b01,
    S_ITER = 2'b10,
    S_FIX  = 2'b11
  } mdu_state_t;

  function automatic logic op_is_div(input mdu_op_t o);
    return (o == OP_DIV) || (o == OP_DIVU);
  endfunction

  function automatic logic op_is_signed(input mdu_op_t o);
    return (o == OP_MULT) || (o == OP_DIV);
  endfunction

endpackage

// File: rtl/mult_div_unit.sv
// Radix-2 iterative multiply/divide unit with HI/LO registers, MTHI/MTLO writes
// and a start/busy/done handshake.
module mult_div_unit
  import mdu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             Clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             hi_we,
  input  logic             lo_we,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output mdu_state_t       state_dbg
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam int W2 = 2 * WIDTH;

  // Handshake: start is taken on any edge while in S_IDLE (including the done
  // cycle); busy is high from that edge through the done cycle, and done is a
  // single-cycle pulse during which hi/lo already hold the new result.

  mdu_state_t       state_q;
  mdu_op_t          op_q;
  logic [WIDTH-1:0] opnd_q, a_raw_q, hi_q, lo_q;
  logic [W2-1:0]    acc_q;
  logic [CW-1:0]    cnt_q;
  logic             neg_p_q, neg_r_q, b_zero_q, busy_q, done_q, dbz_q;

  mdu_op_t          op_in;
  logic             a_neg, b_neg;
  logic [WIDTH-1:0] a_mag, b_mag;
  logic [WIDTH:0]   mul_sum, div_trial;
  logic [W2-1:0]    step_d, prod_d;
  logic [WIDTH-1:0] fix_hi_d, fix_lo_d, rem_d;

  always_comb begin
    op_in = mdu_op_t'(op);
    a_neg = op_is_signed(op_in) & a[WIDTH-1];
    b_neg = op_is_signed(op_in) & b[WIDTH-1];
    a_mag = a_neg ? -a : a;
    b_mag = b_neg ? -b : b;

    // Multiply: add the multiplicand into the upper half, then shift right.
    mul_sum = {1'b0, acc_q[W2-1:WIDTH]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
    // Divide: shift {rem, quot} left one bit and try to subtract the divisor.
    div_trial = {acc_q[W2-1:WIDTH], acc_q[WIDTH-1]} - {1'b0, opnd_q};
    if (op_is_div(op_q)) begin
      step_d = div_trial[WIDTH] ? {acc_q[W2-2:0], 1'b0}
                                : {div_trial[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
    end else begin
      step_d = {mul_sum, acc_q[WIDTH-1:1]};
    end

    prod_d = neg_p_q ? -acc_q : acc_q;
    rem_d  = acc_q[W2-1:WIDTH];
    if (!op_is_div(op_q)) begin
      fix_hi_d = prod_d[W2-1:WIDTH];
      fix_lo_d = prod_d[WIDTH-1:0];
    end else if (b_zero_q) begin
      fix_hi_d = a_raw_q;
      fix_lo_d = '1;
    end else begin
      fix_hi_d = neg_r_q ? -rem_d : rem_d;
      fix_lo_d = neg_p_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
    end
  end

  always_ff @(posedge Clk or negedge reset) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      op_q     <= OP_MULT;
      opnd_q   <= '0;
      a_raw_q  <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      neg_p_q  <= 1'b0;
      neg_r_q  <= 1'b0;
      b_zero_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      dbz_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      dbz_q  <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          busy_q <= 1'b0;
          if (!busy_q && hi_we) hi_q <= wdata;
          if (!busy_q && lo_we) lo_q <= wdata;
          if (start) begin
            // Magnitudes and result signs are taken here so the first
            // radix-2 step can run on the following edge.
            op_q     <= op_in;
            a_raw_q  <= a;
            b_zero_q <= (b == '0);
            opnd_q   <= op_is_div(op_in) ? b_mag : a_mag;
            acc_q    <= {{WIDTH{1'b0}}, (op_is_div(op_in) ? a_mag : b_mag)};
            cnt_q    <= CW'(WIDTH);
            neg_p_q  <= a_neg ^ b_neg;
            neg_r_q  <= a_neg;
            busy_q   <= 1'b1;
            state_q  <= S_PREP;
          end
        end
        S_PREP, S_ITER: begin
          if (state_q == S_PREP && op_is_div(op_q) && b_zero_q) begin
            state_q <= S_FIX;
          end else begin
            acc_q   <= step_d;
            cnt_q   <= cnt_q - CW'(1);
            state_q <= (cnt_q == CW'(1)) ? S_FIX : S_ITER;
          end
        end
        S_FIX: begin
          hi_q    <= fix_hi_d;
          lo_q    <= fix_lo_d;
          dbz_q   <= op_is_div(op_q) & b_zero_q;
          done_q  <= 1'b1;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign div_by_zero = dbz_q;
  assign hi          = hi_q;
  assign lo          = lo_q;
  assign state_dbg   = state_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Self-checking bench for mult_div_unit (WIDTH=32): directed cases, handshake
// boundaries, asynchronous reset and a short random run against a behavioural model.
module tb_mult_div_unit;
  import mdu_pkg::*;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [1:0]   op = 2'b00;
  logic [W-1:0] a = '0, b = '0, wdata = '0;
  logic         hi_we = 1'b0, lo_we = 1'b0;
  logic         busy, done, dbz;
  logic [W-1:0] hi, lo;
  mdu_state_t   state_dbg;

  logic [2*W:0] exp_q[$];
  int           n_cmp = 0;
  int           n_bad = 0;
  logic [W-1:0] last_hi = '0, last_lo = '0, prev_hi;
  logic [1:0]   r_op;
  logic [W-1:0] r_a, r_b;
  int           cyc;

  mult_div_unit #(.WIDTH(W)) dut (
    .Clk(clk), .reset(rst_n), .start(start), .op(op), .a(a), .b(b),
    .hi_we(hi_we), .lo_we(lo_we), .wdata(wdata), .busy(busy), .done(done),
    .div_by_zero(dbz), .hi(hi), .lo(lo), .state_dbg(state_dbg)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Expected {div_by_zero, hi, lo} computed with plain SV arithmetic.
  function automatic logic [2*W:0] model(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
    longint         sx, sy, q, r;
    logic [2*W-1:0] p;
    logic [2*W:0]   res;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    if (o == 2'd0) begin
      p = 64'(sx * sy);
      res = {1'b0, p};
    end else if (o == 2'd1) begin
      p = {{W{1'b0}}, x} * {{W{1'b0}}, y};
      res = {1'b0, p};
    end else if (y == '0) begin
      res = {1'b1, x, {W{1'b1}}};
    end else if (o == 2'd2) begin
      q = sx / sy;
      r = sx % sy;
      res = {1'b0, r[W-1:0], q[W-1:0]};
    end else begin
      res = {1'b0, x % y, x / y};
    end
    return res;
  endfunction

  always @(negedge clk) begin
    if (rst_n && done) begin
      if (exp_q.size() == 0) begin
        check_eq("done_expected", 64'(done), 64'(0));
      end else begin : pop
        logic [2*W:0] e;
        e = exp_q.pop_front();
        check_eq("hi", hi, e[2*W-1:W]);
        check_eq("lo", lo, e[W-1:0]);
        check_eq("div_by_zero", 64'(dbz), 64'(e[2*W]));
      end
    end
  end

  task automatic launch(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
    logic [2*W:0] e;
    start = 1'b1; op = o; a = x; b = y;
    e = model(o, x, y);
    exp_q.push_back(e);
    last_hi = e[2*W-1:W];
    last_lo = e[W-1:0];
  endtask

  task automatic run_op(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
    int n = 0;
    int lat;
    lat = (o[1] && y == '0) ? 3 : W + 2;
    launch(o, x, y);
    do begin
      @(negedge clk);
      n++;
      if (n == 1) begin
        start = 1'b0; a = $urandom; b = $urandom;
      end
    end while (!done && n < 200);
    check_eq("latency", 64'(n), 64'(lat));
    check_eq("busy_at_done", 64'(busy), 64'(1));
    @(negedge clk);
    check_eq("busy_after_done", 64'(busy), 64'(0));
    check_eq("done_one_cycle", 64'(done), 64'(0));
    check_eq("dbz_one_cycle", 64'(dbz), 64'(0));
  endtask

  initial begin
    repeat (2) @(negedge clk);
    check_eq("rst_hi", hi, 0);
    check_eq("rst_lo", lo, 0);
    check_eq("rst_busy", 64'(busy), 0);
    check_eq("rst_done", 64'(done), 0);
    check_eq("rst_dbz", 64'(dbz), 0);
    check_eq("rst_state", 64'(state_dbg), 64'(S_IDLE));
    rst_n = 1'b1;
    @(negedge clk);

    run_op(2'd0, 32'hFFFFFFFD, 32'h7);
    run_op(2'd1, 32'hFFFFFFFF, 32'hFFFFFFFF);
    run_op(2'd2, 32'hFFFFFFF9, 32'h2);
    run_op(2'd2, 32'h80000000, 32'hFFFFFFFF);
    run_op(2'd3, 32'h1234, 32'h0);
    run_op(2'd2, 32'hFFFFFF00, 32'h0);
    run_op(2'd3, 32'hFFFFFFFF, 32'h1);

    // start and MTHI while busy must both be ignored
    prev_hi = last_hi;
    launch(2'd1, 32'd5, 32'd6);
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
      if (cyc == 1) start = 1'b0;
      if (cyc == 10) begin
        check_eq("state_iter", 64'(state_dbg), 64'(S_ITER));
        start = 1'b1; op = 2'd2; a = 32'd9; b = 32'd3; hi_we = 1'b1; wdata = 32'hAA;
      end
      if (cyc == 11) begin
        start = 1'b0; hi_we = 1'b0;
      end
      if (cyc == 12) check_eq("mthi_while_busy", hi, prev_hi);
    end while (!done && cyc < 200);
    check_eq("latency_busy_start", 64'(cyc), 64'(W + 2));
    repeat (40) @(negedge clk);
    check_eq("idle_after_ignored_start", 64'(busy), 0);

    // asynchronous reset in the middle of an iteration
    launch(2'd0, 32'h12345678, 32'h9);
    @(negedge clk);
    start = 1'b0;
    repeat (19) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check_eq("async_rst_busy", 64'(busy), 0);
    check_eq("async_rst_done", 64'(done), 0);
    check_eq("async_rst_dbz", 64'(dbz), 0);
    check_eq("async_rst_hi", hi, 0);
    check_eq("async_rst_lo", lo, 0);
    check_eq("async_rst_state", 64'(state_dbg), 64'(S_IDLE));
    exp_q.delete();
    last_hi = '0;
    last_lo = '0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run_op(2'd0, 32'd2, 32'd3);

    // idle MTLO / MTHI
    lo_we = 1'b1; wdata = 32'hDEADBEEF;
    @(negedge clk);
    lo_we = 1'b0;
    check_eq("mtlo_lo", lo, 32'hDEADBEEF);
    check_eq("mtlo_hi_kept", hi, last_hi);
    check_eq("mtlo_no_done", 64'(done), 0);
    last_lo = 32'hDEADBEEF;
    hi_we = 1'b1; wdata = 32'h13579BDF;
    @(negedge clk);
    hi_we = 1'b0;
    check_eq("mthi_hi", hi, 32'h13579BDF);
    check_eq("mthi_lo_kept", lo, last_lo);

    for (int i = 0; i < 10; i++) begin
      r_op = 2'($urandom_range(0, 3));
      r_a  = $urandom;
      r_b  = $urandom;
      if ($urandom_range(0, 4) == 0) r_b = '0;
      else if ($urandom_range(0, 3) == 0) r_b = 32'($urandom_range(1, 15));
      run_op(r_op, r_a, r_b);
    end

    check_eq("queue_drained", 64'(exp_q.size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
